onehot_slot_alloc: RTL

Registered slot allocator over a WIDTH-entry pool. It hands out the lowest free entry as a one-hot grant plus binary index, and returns entries by release mask. Its busy mask is the occupancy vector consumed downstream by the last-one finder that locates the youngest occupied entry. It sits on the enqueue side of the collapsing queues, as the writer to that finder's reader.

---
 rtl/onehot_slot_alloc_pkg.sv | 27 ++
 rtl/onehot_slot_alloc_find_first0.sv | 21 ++
 rtl/onehot_slot_alloc.sv | 88 ++++++++
 3 files changed

// File: rtl/onehot_slot_alloc_pkg.sv
// Shared types and helpers for the slot allocator and the last-one finder users.
// Sizing limit: helpers operate on masks up to MAX_W bits.
package onehot_slot_alloc_pkg;

    localparam int SLOT_W = 8;
    localparam int MAX_W  = 64;

    typedef logic [SLOT_W-1:0] slot_mask_t;

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_W; i++)
            cnt = cnt + 32'(v[i]);
        return cnt;
    endfunction

    // Index of a one-hot vector; all-zero input yields 0.
    function automatic int unsigned oh2idx(input logic [MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_W; i++)
            if (oh[i]) idx = idx | 32'(i);
        return idx;
    endfunction

endpackage

// File: rtl/onehot_slot_alloc_find_first0.sv
// Combinational lowest-zero finder: one-hot of the lowest clear bit, zero if all set.
module find_first0 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_oh
);

    logic w_run;

    // w_run stays high while every lower bit is set.
    always_comb begin
        o_oh  = '0;
        w_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            o_oh[i] = w_run & ~i_vec[i];
            w_run   = w_run & i_vec[i];
        end
    end

endmodule

// File: rtl/onehot_slot_alloc.sv
// Registered lowest-free slot allocator with release-by-mask.
// Define ALLOC_FREE_BYPASS_EN to let a full pool grant a slot released in the same cycle.
module onehot_slot_alloc
    import onehot_slot_alloc_pkg::*;
#(
    parameter int WIDTH = SLOT_W,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [WIDTH-1:0] alloc_oh,
    output logic [IDXW-1:0]  alloc_idx,
    input  logic             free_valid,
    input  logic [WIDTH-1:0] free_mask,
    output logic [WIDTH-1:0] busy_mask,
    output logic [IDXW:0]    free_count,
    output logic             full,
    output logic             empty
);

    localparam logic [IDXW:0] CNT_ALL = (IDXW+1)'(WIDTH);

    logic [WIDTH-1:0] r_busy;
    logic [IDXW:0]    r_free_count;

    logic             w_full;
    logic             w_open;
    logic             w_fire;
    logic [WIDTH-1:0] w_rel;
    logic [WIDTH-1:0] w_first0;
    logic [WIDTH-1:0] w_grant;
    logic [IDXW:0]    w_rel_cnt;

    assign w_full = &r_busy;
    assign w_open = ~flush & ~reset;
    // Only busy slots count as released; stray bits are dropped here.
    assign w_rel  = free_mask & r_busy & {WIDTH{free_valid}};

    find_first0 #(.WIDTH(WIDTH)) u_first0 (
        .i_vec (r_busy),
        .o_oh  (w_first0)
    );

`ifdef ALLOC_FREE_BYPASS_EN
    logic [WIDTH-1:0] w_byp_oh;
    logic             w_byp;

    find_first0 #(.WIDTH(WIDTH)) u_byp_first0 (
        .i_vec (~(free_mask & r_busy)),
        .o_oh  (w_byp_oh)
    );

    assign w_byp       = w_full & free_valid & (|(free_mask & r_busy));
    assign alloc_ready = (~w_full | w_byp) & w_open;
    assign w_grant     = w_full ? w_byp_oh : w_first0;
`else
    assign alloc_ready = ~w_full & w_open;
    assign w_grant     = w_first0;
`endif

    assign alloc_oh  = alloc_ready ? w_grant : '0;
    assign alloc_idx = IDXW'(oh2idx(MAX_W'(alloc_oh)));
    assign w_fire    = alloc_valid & alloc_ready;
    assign w_rel_cnt = (IDXW+1)'(popcount(MAX_W'(w_rel)));

    // A bypassed slot is cleared by w_rel and re-set by the grant: net busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy       <= '0;
            r_free_count <= CNT_ALL;
        end else if (flush) begin
            r_busy       <= '0;
            r_free_count <= CNT_ALL;
        end else begin
            r_busy       <= (r_busy & ~w_rel) | (w_fire ? alloc_oh : '0);
            r_free_count <= r_free_count + w_rel_cnt - {{IDXW{1'b0}}, w_fire};
        end
    end

    assign busy_mask  = r_busy;
    assign free_count = r_free_count;
    assign full       = w_full;
    assign empty      = ~|r_busy;

endmodule
